qlm_err_acc: RTL
================

QLM_ERR_ACC -- requirements
Module: qlm_err_acc

Interface
REQ-001 Parameter ACC_W, default 48: width of the error-sum accumulator; legal range 33..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a measurement run.
REQ-005 n_target  input  16  number of samples to accept in the run; latched when start is accepted.
REQ-006 in_valid  input  1  sample present on x, y and p_approx.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 x, y  input  16 each  unsigned multiplier operands that produced p_approx.
REQ-009 p_approx  input  32  registered product from the upstream approximate multiplier.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  one-cycle pulse at the end of a run.
REQ-012 err_sum  output  ACC_W  saturating sum of absolute errors.
REQ-013 nz_cnt  output  16  count of samples with a non-zero error.
REQ-014 max_err  output  32  largest absolute error in the run.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on start: latch n_target; clear err_sum, nz_cnt and max_err; clear the accept counter.
- start while not in IDLE is ignored.
REQ-016 RUN: in_ready = 1 while the accept count is below n_target. A sample is accepted on an edge where in_valid and in_ready are both 1.
- Gaps in in_valid stall the run without loss.
- On the edge that accepts sample number n_target, in_ready deasserts and the FSM enters DRAIN.
REQ-017 n_target = 0: the FSM goes IDLE to DONE directly; no samples are accepted and the results stay 0.
REQ-018 Pipeline, three registered stages:
- S1 registers x*y (exact, 32-bit) and p_approx.
- S2 registers err = |exact - p_approx| (32-bit unsigned).
- S3 updates the accumulators.
REQ-019 A sample accepted at edge k is reflected in the outputs after edge k+3.
REQ-020 DRAIN lasts until the last sample has passed S3. DONE follows and lasts one cycle (done = 1), then the FSM returns to IDLE.
- done is high exactly 4 cycles after the edge that accepted the last sample.
REQ-021 err_sum adds err zero-extended to ACC_W and saturates at 2^ACC_W - 1; it never wraps.
REQ-022 nz_cnt increments when err != 0 and saturates at 0xFFFF.
REQ-023 Outputs hold their final values in IDLE until the next accepted start.
REQ-024 in_ready = 0 in IDLE, DRAIN and DONE.

Reset
REQ-025 While rst = 1 at an edge, the following clear to 0: FSM (to IDLE), pipeline valid flags, accept counter, err_sum, nz_cnt, max_err, done, busy and in_ready.
REQ-026 Reset mid-run discards all in-flight samples; done does not pulse for the aborted run.

Configuration
REQ-027 Macro QLM_ERR_MAX_EN selects max-error tracking.
- Defined: max_err updates to err in S3 whenever err > max_err, and clears at start.
- Undefined: no comparator or register is built and max_err is tied to 0.
- All other behaviour is identical either way.

Verification
REQ-028 Reset test: assert rst for 2 cycles during RUN -> next cycle busy = 0, in_ready = 0, err_sum = 0, nz_cnt = 0, max_err = 0, and no done pulse.
REQ-029 Basic run, ACC_W = 48, n_target = 3, samples in consecutive cycles:
- Samples: (3, 5, 15), (100, 100, 9990), (65535, 65535, 0xFFFE0001).
- Required: err_sum = 10, nz_cnt = 1, max_err = 10 (with QLM_ERR_MAX_EN) or 0 (without), and a single done pulse 4 cycles after the third accept.
REQ-030 Edge cases:
- start with n_target = 0 -> done pulses one cycle after the start edge; in_ready is never high; outputs are 0.
- n_target = 2 with in_valid toggling 1,0,0,1 -> exactly 2 accepts; done 4 cycles after the second accept.
- start pulsed during RUN -> ignored, and accumulators are not cleared.
REQ-031 Saturation, ACC_W = 33, n_target = 4, each sample x = y = 65535 with p_approx = 0 -> err_sum = 0x1FFFFFFFF and nz_cnt = 4.

Source files
------------

// File: rtl/qlm_err_acc.sv
// ---------------------------------------------------------------------------
// qlm_err_acc -- error accumulator for characterising an approximate
// multiplier. Each accepted sample (x, y, p_approx) is compared against the
// exact product x*y; the absolute error is summed (saturating), non-zero
// errors are counted (saturating) and, optionally, the largest error is kept.
//
// Build option:
//   QLM_ERR_MAX_EN  defined   -> max_err tracks the largest error of the run
//                   undefined -> no max tracking, max_err tied to 0
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     single-cycle run request (honoured only in IDLE)
//   n_target  samples per run, latched with start
//   in_valid  sample present on x / y / p_approx
//   in_ready  sample accepted this cycle when in_valid is also high
//   x, y      16-bit unsigned operands
//   p_approx  32-bit product from the approximate multiplier
//   busy      high in RUN and DRAIN
//   done      one-cycle end-of-run pulse
//   err_sum   saturating sum of |x*y - p_approx|
//   nz_cnt    saturating count of non-zero errors
//   max_err   largest error of the run (0 without QLM_ERR_MAX_EN)
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start, results held
// ST_RUN   | accepting samples until n_target have been taken
// ST_DRAIN | last sample travelling through the pipeline
// ST_DONE  | results final, done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module qlm_err_acc #(
   parameter int ACC_W = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      n_target,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      x,
   input  logic [15:0]      y,
   input  logic [31:0]      p_approx,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] err_sum,
   output logic [15:0]      nz_cnt,
   output logic [31:0]      max_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] acc_cnt_q, acc_cnt_d;
   logic [15:0] acc_cnt_inc;
   logic [1:0]  drain_q, drain_d;
   logic        accept;
   logic        run_start;

   assign in_ready    = (state_q == ST_RUN) && (acc_cnt_q < n_q);
   assign accept      = in_valid && in_ready;
   assign run_start   = (state_q == ST_IDLE) && start;
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done        = (state_q == ST_DONE);
   assign acc_cnt_inc = acc_cnt_q + 16'd1;

   // DRAIN down-counter: loaded with 2 on the last accept so that DONE is
   // entered on the same edge the last sample lands in the accumulators.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      acc_cnt_d = acc_cnt_q;
      drain_d   = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               n_d       = n_target;
               acc_cnt_d = 16'd0;
               state_d   = (n_target == 16'd0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               acc_cnt_d = acc_cnt_inc;
               if (acc_cnt_inc == n_q) begin
                  state_d = ST_DRAIN;
                  drain_d = 2'd2;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == 2'd0) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q - 2'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= 16'd0;
         acc_cnt_q <= 16'd0;
         drain_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         acc_cnt_q <= acc_cnt_d;
         drain_q   <= drain_d;
      end
   end

   // Pipeline: S1 exact product, S2 absolute error, S3 error staged for the
   // accumulators. Only the valid flags need reset; data is qualified by them.
   logic        s1_v_q, s2_v_q, s3_v_q;
   logic [31:0] s1_prod_q, s1_pa_q, s2_err_q, s3_err_q;
   logic [31:0] prod_exact;
   logic [31:0] err_abs;

   assign prod_exact = {16'd0, x} * {16'd0, y};
   assign err_abs    = (s1_prod_q >= s1_pa_q) ? (s1_prod_q - s1_pa_q)
                                              : (s1_pa_q - s1_prod_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         s3_v_q <= 1'b0;
      end else begin
         s1_v_q <= accept;
         s2_v_q <= s1_v_q;
         s3_v_q <= s2_v_q;
      end
   end

   always_ff @(posedge clk) begin
      s1_prod_q <= prod_exact;
      s1_pa_q   <= p_approx;
      s2_err_q  <= err_abs;
      s3_err_q  <= s2_err_q;
   end

   // One extra carry bit is enough: err < 2^32 <= 2^ACC_W.
   logic [ACC_W-1:0] sum_q;
   logic [ACC_W:0]   sum_ext;
   logic [15:0]      nz_q;

   assign sum_ext = {1'b0, sum_q} + {{(ACC_W-31){1'b0}}, s3_err_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
         nz_q  <= 16'd0;
      end else if (run_start) begin
         sum_q <= '0;
         nz_q  <= 16'd0;
      end else if (s3_v_q) begin
         sum_q <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
         if ((s3_err_q != 32'd0) && (nz_q != 16'hFFFF)) begin
            nz_q <= nz_q + 16'd1;
         end
      end
   end

   assign err_sum = sum_q;
   assign nz_cnt  = nz_q;

`ifdef QLM_ERR_MAX_EN
   logic [31:0] max_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         max_q <= 32'd0;
      end else if (run_start) begin
         max_q <= 32'd0;
      end else if (s3_v_q && (s3_err_q > max_q)) begin
         max_q <= s3_err_q;
      end
   end

   assign max_err = max_q;
`else
   assign max_err = 32'd0;
`endif

endmodule
